// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction-memory fetch path. It takes a byte stream
//   that starts with a 2-byte big-endian word count N, followed by N 32-bit
//   words sent most-significant byte first. Each word is written to
//   instruction memory at consecutive word addresses starting at 0. The CPU
//   is held in stall until the whole image has been written.
//
// Parameters
//   ADDR_WIDTH   word-address width; memory depth is 2^ADDR_WIDTH words
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-high
//   start         in   one-cycle pulse that begins a load session
//                      (honoured only in IDLE, DONE or ERROR)
//   in_valid      in   byte source has a byte on in_data
//   in_data       in   stream byte
//   in_ready      out  loader accepts a byte this cycle
//   mem_we        out  one-cycle write pulse per assembled word
//   mem_addr      out  word address of the write
//   mem_wdata     out  assembled instruction word
//   cpu_hold      out  1 = processor stalled
//   done          out  load finished (level)
//   error         out  header length exceeds the memory depth (level)
//   words_loaded  out  words written in this session
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_in_ready;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_cpu_hold;
    logic                  r_done;
    logic                  r_error;
    logic [ADDR_WIDTH:0]   r_words_loaded;
    logic [15:0]           r_len;
    logic [23:0]           r_buf;
    logic [1:0]            r_byte_cnt;

    logic                  w_in_ready_nxt;
    logic                  w_mem_we_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic [31:0]           w_mem_wdata_nxt;
    logic                  w_cpu_hold_nxt;
    logic                  w_done_nxt;
    logic                  w_error_nxt;
    logic [ADDR_WIDTH:0]   w_words_loaded_nxt;
    logic [15:0]           w_len_nxt;
    logic [23:0]           w_buf_nxt;
    logic [1:0]            w_byte_cnt_nxt;

    logic                  w_xfer;
    logic [15:0]           w_len_full;
    logic                  w_len_zero;
    logic                  w_len_too_big;
    logic [ADDR_WIDTH:0]   w_wl_inc;
    logic                  w_last_word;

    assign w_xfer        = in_valid & r_in_ready;
    // Full length as it will be once the low byte is captured this cycle.
    assign w_len_full    = {r_len[15:8], in_data};
    assign w_len_zero    = (w_len_full == 16'd0);
    assign w_len_too_big = (32'(w_len_full) > DEPTH);
    assign w_wl_inc      = r_words_loaded + 1'b1;
    assign w_last_word   = (32'(w_wl_inc) == 32'(r_len));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) w_next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_xfer) w_next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    if (w_len_zero)         w_next_state = S_DONE;
                    else if (w_len_too_big) w_next_state = S_ERROR;
                    else                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer && r_byte_cnt == 2'd3) w_next_state = S_WRITE;
            end
            S_WRITE: begin
                w_next_state = w_last_word ? S_DONE : S_DATA;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and datapath
    always_comb begin
        w_in_ready_nxt     = r_in_ready;
        w_mem_we_nxt       = r_mem_we;
        w_mem_addr_nxt     = r_mem_addr;
        w_mem_wdata_nxt    = r_mem_wdata;
        w_cpu_hold_nxt     = r_cpu_hold;
        w_done_nxt         = r_done;
        w_error_nxt        = r_error;
        w_words_loaded_nxt = r_words_loaded;
        w_len_nxt          = r_len;
        w_buf_nxt          = r_buf;
        w_byte_cnt_nxt     = r_byte_cnt;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_done_nxt         = 1'b0;
                    w_error_nxt        = 1'b0;
                    w_words_loaded_nxt = '0;
                    w_mem_addr_nxt     = '0;
                    w_byte_cnt_nxt     = 2'd0;
                    w_cpu_hold_nxt     = 1'b1;
                    w_in_ready_nxt     = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) w_len_nxt = {in_data, r_len[7:0]};
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    w_len_nxt = w_len_full;
                    if (w_len_zero) begin
                        w_done_nxt     = 1'b1;
                        w_cpu_hold_nxt = 1'b0;
                        w_in_ready_nxt = 1'b0;
                    end else if (w_len_too_big) begin
                        w_error_nxt    = 1'b1;
                        w_cpu_hold_nxt = 1'b1;
                        w_in_ready_nxt = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    // Earlier bytes shift up so the first byte ends up as the MSB.
                    w_buf_nxt      = {r_buf[15:0], in_data};
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_mem_wdata_nxt = {r_buf, in_data};
                        w_mem_we_nxt    = 1'b1;
                        w_in_ready_nxt  = 1'b0;
                    end
                end
            end
            S_WRITE: begin
                w_mem_we_nxt       = 1'b0;
                w_words_loaded_nxt = w_wl_inc;
                if (w_last_word) begin
                    // Address stays on the final index so a full-depth image never wraps.
                    w_done_nxt     = 1'b1;
                    w_cpu_hold_nxt = 1'b0;
                end else begin
                    w_mem_addr_nxt = r_mem_addr + 1'b1;
                    w_in_ready_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_ready     <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_cpu_hold     <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= '0;
            r_len          <= '0;
            r_buf          <= '0;
            r_byte_cnt     <= 2'd0;
        end else begin
            r_in_ready     <= w_in_ready_nxt;
            r_mem_we       <= w_mem_we_nxt;
            r_mem_addr     <= w_mem_addr_nxt;
            r_mem_wdata    <= w_mem_wdata_nxt;
            r_cpu_hold     <= w_cpu_hold_nxt;
            r_done         <= w_done_nxt;
            r_error        <= w_error_nxt;
            r_words_loaded <= w_words_loaded_nxt;
            r_len          <= w_len_nxt;
            r_buf          <= w_buf_nxt;
            r_byte_cnt     <= w_byte_cnt_nxt;
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign cpu_hold     = r_cpu_hold;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. Streams are built from word lists;
//   the expected memory writes are simply "word i at address i", compared
//   against the write pulses captured from the DUT.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW-1:0] cap_addr[$];
    logic [31:0]   cap_data[$];
    logic [31:0]   exp_w[$];
    bit            sess = 1'b0;
    int            rdy_low = 0;

    // Monitor: samples 1 ns after the rising edge.
    always @(posedge clock) begin
        #1;
        if (mem_we) begin
            cap_addr.push_back(mem_addr);
            cap_data.push_back(mem_wdata);
        end
        if (sess && !in_ready && !done && !error) rdy_low++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_mem_we"},   64'(mem_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_wdata"},    64'(mem_wdata), 64'd0);
        chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
        chk({tag, "_done"},     64'(done), 64'd0);
        chk({tag, "_error"},    64'(error), 64'd0);
        chk({tag, "_words"},    64'(words_loaded), 64'd0);
    endtask

    task automatic fill_random(input int n);
        exp_w.delete();
        for (int i = 0; i < n; i++) exp_w.push_back($urandom);
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cap_addr.delete();
        cap_data.delete();
        rdy_low = 0;
        sess = 1'b1;
        chk("start_rdy",   64'(in_ready), 64'd1);
        chk("start_hold",  64'(cpu_hold), 64'd1);
        chk("start_clear", 64'({done, error, words_loaded}), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk("byte_accept", 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    // gapmode < 0: random idle gap per byte. start_at: byte index after which
    // a stray start pulse is issued (-1 for none).
    task automatic run_load(input int gapmode, input int start_at);
        int         n;
        int         g;
        int         t;
        logic [7:0] stream[$];
        n = exp_w.size();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        foreach (exp_w[i])
            for (int k = 3; k >= 0; k--) stream.push_back(exp_w[i][8*k +: 8]);
        do_start();
        foreach (stream[j]) begin
            g = (gapmode < 0) ? int'($urandom_range(0, 4)) : gapmode;
            send_byte(stream[j], g);
            if (j == start_at) begin
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
            end
        end
        t = 0;
        while (!done && !error && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk("ld_done",     64'(done), 64'd1);
        chk("ld_error",    64'(error), 64'd0);
        chk("ld_hold",     64'(cpu_hold), 64'd0);
        chk("ld_in_ready", 64'(in_ready), 64'd0);
        chk("ld_words",    64'(words_loaded), 64'(n));
        chk("ld_addr",     64'(mem_addr), 64'((n == 0) ? 0 : n - 1));
        chk("ld_nwrites",  64'(cap_addr.size()), 64'(n));
        chk("ld_rdy_low",  64'(rdy_low), 64'(n));
        for (int i = 0; i < n && i < cap_addr.size(); i++) begin
            chk("ld_waddr", 64'(cap_addr[i]), 64'(i));
            chk("ld_wdata", 64'(cap_data[i]), 64'(exp_w[i]));
        end
        sess = 1'b0;
    endtask

    task automatic run_err(input logic [15:0] len);
        do_start();
        send_byte(len[15:8], 0);
        send_byte(len[7:0], 0);
        chk("err_error",    64'(error), 64'd1);
        chk("err_hold",     64'(cpu_hold), 64'd1);
        chk("err_in_ready", 64'(in_ready), 64'd0);
        chk("err_done",     64'(done), 64'd0);
        chk("err_words",    64'(words_loaded), 64'd0);
        // Bytes offered in ERROR must be refused.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(negedge clock);
        in_valid = 1'b0;
        chk("err_stay",     64'(error), 64'd1);
        chk("err_nrdy",     64'(in_ready), 64'd0);
        chk("err_nwrites",  64'(cap_addr.size()), 64'd0);
        sess = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clock);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clock);

        // Directed two-word image, continuous then gapped source
        exp_w = '{32'h00000020, 32'h012A4019};
        run_load(0, -1);
        run_load(3, -1);

        // Asynchronous reset in the middle of a cycle
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("arst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Zero-length image
        exp_w.delete();
        run_load(0, -1);

        // Oversized header, then a fresh start must clear the error
        run_err(16'd1025);
        fill_random(3);
        run_load(-1, -1);

        // Reset after six bytes of a two-word image
        exp_w = '{32'h00000020, 32'h012A4019};
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int k = 3; k >= 0; k--) send_byte(exp_w[0][8*k +: 8], 0);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        chk("midrst_nwrites", 64'(cap_addr.size() <= 1), 64'd1);
        if (cap_addr.size() == 1) begin
            chk("midrst_waddr", 64'(cap_addr[0]), 64'd0);
            chk("midrst_wdata", 64'(cap_data[0]), 64'(exp_w[0]));
        end
        sess = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_load(0, -1);

        // Stray start while streaming data
        fill_random(4);
        run_load(-1, 5);

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            fill_random(int'($urandom_range(1, 8)));
            run_load(-1, int'($urandom_range(0, 20)));
        end
        for (int s = 0; s < 2; s++) begin
            run_err(16'($urandom_range(1025, 65535)));
        end

        // Full-depth image
        fill_random(1 << AW);
        run_load(0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
